// File: rtl/layer_pkg.sv
// Shared layer definitions: sequencer state encoding, default macro timing and width helpers.
package layer_pkg;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LATCH, SEQ_CONV, SEQ_READ} seq_state_t;

  localparam int DEF_LATCH_CYC = 1;
  localparam int DEF_ADC_CYC   = 4;

  // Keeps every derived bus at least one bit wide, even when a count of 1 is configured.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fm_pos_counter.sv
// Column/row position of the feature map: steps once per finished column, wraps at the
// frame edges and reports the wrap conditions of the current step.
module fm_pos_counter
  import layer_pkg::*;
#(
  parameter int FM_WIDTH  = 56,
  parameter int FM_HEIGHT = 56,
  localparam int COL_W    = clog2_min1(FM_WIDTH),
  localparam int ROW_W    = clog2_min1(FM_HEIGHT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             step,
  output logic [COL_W-1:0] col_idx,
  output logic [ROW_W-1:0] row_idx,
  output logic             col_wrap,
  output logic             row_wrap
);

  logic col_last;
  logic row_last;

  assign col_last = (col_idx == COL_W'(FM_WIDTH - 1));
  assign row_last = (row_idx == ROW_W'(FM_HEIGHT - 1));

  // row_wrap only means a frame end when qualified with col_wrap by the user.
  assign col_wrap = step && col_last;
  assign row_wrap = step && row_last;

  // Clear beats step so a frame start coinciding with a column end lands on 0/0.
  always_ff @(posedge clk) begin
    if (rstn || clear) begin
      col_idx <= '0;
      row_idx <= '0;
    end else if (step) begin
      if (col_last) begin
        col_idx <= '0;
        row_idx <= row_last ? '0 : row_idx + ROW_W'(1);
      end else begin
        col_idx <= col_idx + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/macro_sequencer_layer4.sv
// Layer-4 CIM macro sequencer: per accepted column it strobes latch then adc, then reads the
// macros out one per cycle while tracking feature-map position and upstream protocol errors.
module macro_sequencer_layer4
  import layer_pkg::*;
#(
  parameter int FM_WIDTH  = 56,
  parameter int FM_HEIGHT = 56,
  parameter int MACRO_NUM = 4,
  parameter int LATCH_CYC = DEF_LATCH_CYC,
  parameter int ADC_CYC   = DEF_ADC_CYC,
  localparam int SEL_W    = clog2_min1(MACRO_NUM),
  localparam int COL_W    = clog2_min1(FM_WIDTH),
  localparam int ROW_W    = clog2_min1(FM_HEIGHT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode_in,
  input  logic             vs,
  input  logic             data_e,
  output logic             ready,
  output logic             latch,
  output logic             adc,
  output logic             rd_e,
  output logic [SEL_W-1:0] rd_sel,
  output logic [COL_W-1:0] col_idx,
  output logic [ROW_W-1:0] row_idx,
  output logic             col_done,
  output logic             frame_done,
  output logic             overrun
);

  localparam int PH_MAX = max3(LATCH_CYC, ADC_CYC, MACRO_NUM);
  localparam int PH_W   = clog2_min1(PH_MAX);

  seq_state_t      state;
  seq_state_t      next_state;
  logic [PH_W-1:0] phase;
  logic            mode_q;
  logic            accept;
  logic            col_wrap;
  logic            row_wrap;

  assign accept = ready && data_e && mode_in;

  // State register; phase restarts on every state change and idles at zero.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state  <= SEQ_IDLE;
      phase  <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= next_state;
      mode_q <= mode_in;
      if ((next_state != state) || (state == SEQ_IDLE)) begin
        phase <= '0;
      end else begin
        phase <= phase + PH_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    if (!mode_in) begin
      next_state = SEQ_IDLE;
    end else begin
      case (state)
        SEQ_IDLE:  if (accept) next_state = SEQ_LATCH;
        SEQ_LATCH: if (phase == PH_W'(LATCH_CYC - 1)) next_state = SEQ_CONV;
        SEQ_CONV:  if (phase == PH_W'(ADC_CYC - 1)) next_state = SEQ_READ;
        SEQ_READ:  if (phase == PH_W'(MACRO_NUM - 1)) next_state = SEQ_IDLE;
        default:   next_state = SEQ_IDLE;
      endcase
    end
  end

  // Outputs decode only flops, so nothing combinational from the inputs reaches a port.
  always_comb begin
    ready    = 1'b0;
    latch    = 1'b0;
    adc      = 1'b0;
    rd_e     = 1'b0;
    rd_sel   = '0;
    col_done = 1'b0;
    case (state)
      SEQ_IDLE:  ready = mode_q;
      SEQ_LATCH: latch = 1'b1;
      SEQ_CONV:  adc   = 1'b1;
      SEQ_READ: begin
        rd_e     = 1'b1;
        rd_sel   = SEL_W'(phase);
        col_done = (phase == PH_W'(MACRO_NUM - 1));
      end
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      overrun <= 1'b0;
    end else if (data_e && !ready) begin
      overrun <= 1'b1;
    end
  end

  fm_pos_counter #(
    .FM_WIDTH  (FM_WIDTH),
    .FM_HEIGHT (FM_HEIGHT)
  ) u_pos (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (vs),
    .step     (col_done),
    .col_idx  (col_idx),
    .row_idx  (row_idx),
    .col_wrap (col_wrap),
    .row_wrap (row_wrap)
  );

  // Taken from the pre-step position, so a coinciding vs cannot hide the frame end.
  assign frame_done = col_wrap && row_wrap;

endmodule

// File: tb/tb_macro_sequencer_layer4.sv
// Scoreboard bench for macro_sequencer_layer4: each accepted column queues its expected read-out
// beats, which are popped and compared whenever the sequencer drives rd_e.
module tb_macro_sequencer_layer4;

  localparam int W         = 56;
  localparam int H         = 56;
  localparam int MN        = 4;
  localparam int LAT       = 1;
  localparam int ADC       = 4;
  localparam int RD_OFF    = 1 + LAT + ADC;
  localparam int READY_OFF = RD_OFF + MN;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       mode_in = 1'b1;
  logic       vs = 1'b0;
  logic       data_e = 1'b0;
  logic       ready, latch, adc, rd_e, col_done, frame_done, overrun;
  logic [1:0] rd_sel;
  logic [5:0] col_idx, row_idx;

  typedef struct {
    int cyc;
    int sel;
    bit cdone;
    bit fdone;
    int col;
    int row;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    ex_col = 0;
  int    ex_row = 0;
  int    col_done_cnt = 0;
  int    frame_done_cnt = 0;
  int    next_ready_cyc = -1;
  int    acc = 0;
  int    n0 = 0;

  macro_sequencer_layer4 #(
    .FM_WIDTH  (W),
    .FM_HEIGHT (H),
    .MACRO_NUM (MN),
    .LATCH_CYC (LAT),
    .ADC_CYC   (ADC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mode_in    (mode_in),
    .vs         (vs),
    .data_e     (data_e),
    .ready      (ready),
    .latch      (latch),
    .adc        (adc),
    .rd_e       (rd_e),
    .rd_sel     (rd_sel),
    .col_idx    (col_idx),
    .row_idx    (row_idx),
    .col_done   (col_done),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Expected beats carry the position of the column itself; the model then moves to the next column.
  task automatic push_column(input int acc_cyc, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.cyc   = acc_cyc + RD_OFF + i;
      b.sel   = i;
      b.cdone = (i == MN - 1);
      b.fdone = (i == MN - 1) && (ex_col == W - 1) && (ex_row == H - 1);
      b.col   = ex_col;
      b.row   = ex_row;
      exp_q.push_back(b);
    end
    if (nbeats == MN) begin
      if (ex_col == W - 1) begin
        ex_col = 0;
        ex_row = (ex_row == H - 1) ? 0 : ex_row + 1;
      end else begin
        ex_col++;
      end
    end
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) checkOutput("ready_timeout", 0, 1);
    else if (n > 0 && next_ready_cyc >= 0) checkOutput("ready_return_cyc", cyc, next_ready_cyc);
  endtask

  // Offers one column on the next ready window; nbeats < MN models a column that will be cut short.
  task automatic applyStimulus(input bit with_vs, input int nbeats);
    wait_ready(64);
    acc    = cyc;
    data_e = 1'b1;
    vs     = with_vs;
    if (with_vs) begin
      ex_col = 0;
      ex_row = 0;
    end
    push_column(acc, nbeats);
    next_ready_cyc = acc + READY_OFF;
    @(posedge clk);
    #1;
    data_e = 1'b0;
    vs     = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rd_e === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("rd_e_unexpected", 1, 0);
      end else begin
        mon_b = exp_q.pop_front();
        checkOutput("beat_cycle", cyc, mon_b.cyc);
        checkOutput("beat_rd_sel", rd_sel, mon_b.sel);
        checkOutput("beat_col_done", col_done, mon_b.cdone);
        checkOutput("beat_frame_done", frame_done, mon_b.fdone);
        checkOutput("beat_col_idx", col_idx, mon_b.col);
        checkOutput("beat_row_idx", row_idx, mon_b.row);
      end
    end else if (col_done !== 1'b0 || frame_done !== 1'b0) begin
      checkOutput("stray_done", {col_done, frame_done}, 0);
    end
    if (col_done === 1'b1) col_done_cnt++;
    if (frame_done === 1'b1) frame_done_cnt++;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", ready, 0);
    checkOutput("reset_latch", latch, 0);
    checkOutput("reset_adc", adc, 0);
    checkOutput("reset_rd_e", rd_e, 0);
    checkOutput("reset_rd_sel", rd_sel, 0);
    checkOutput("reset_col", col_idx, 0);
    checkOutput("reset_row", row_idx, 0);
    checkOutput("reset_overrun", overrun, 0);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", ready, 1);

    // Single column: strobe timing relative to the accept cycle
    while (cyc < 10) @(negedge clk);
    applyStimulus(1'b0, MN);
    for (int c = acc + 1; c <= acc + READY_OFF; c++) begin
      checkOutput("t1_latch", latch, (c - acc) <= LAT);
      checkOutput("t1_adc", adc, ((c - acc) > LAT) && ((c - acc) <= LAT + ADC));
      checkOutput("t1_rd_e", rd_e, ((c - acc) > LAT + ADC) && ((c - acc) <= LAT + ADC + MN));
      checkOutput("t1_ready", ready, (c - acc) == READY_OFF);
      if (c < acc + READY_OFF) @(negedge clk);
    end
    checkOutput("t1_col_after", col_idx, 1);
    checkOutput("t1_row_after", row_idx, 0);

    // Full frame, first column coinciding with vs
    applyStimulus(1'b1, MN);
    for (int i = 1; i < W * H; i++) applyStimulus(1'b0, MN);
    wait_ready(64);
    checkOutput("frame_col_wrap", col_idx, 0);
    checkOutput("frame_row_wrap", row_idx, 0);
    checkOutput("frame_done_count", frame_done_cnt, 1);
    checkOutput("col_done_count", col_done_cnt, 1 + W * H);
    checkOutput("overrun_clean", overrun, 0);

    // data_e held high across several ready windows
    wait_ready(64);
    n0 = cyc;
    data_e = 1'b1;
    for (int c = 0; c <= 2 * READY_OFF; c++) begin
      if (c % READY_OFF == 0) begin
        checkOutput("t3_ready_window", ready, 1);
        push_column(cyc, MN);
        next_ready_cyc = cyc + READY_OFF;
      end
      if (c == 1) checkOutput("t3_overrun_not_yet", overrun, 0);
      if (c == 2) checkOutput("t3_overrun_set", overrun, 1);
      @(negedge clk);
    end
    data_e = 1'b0;
    wait_ready(64);
    checkOutput("t3_overrun_sticky", overrun, 1);
    checkOutput("t3_col_after", col_idx, ex_col);

    // mode_in dropped during conversion aborts the column
    applyStimulus(1'b0, 0);
    while (cyc < acc + LAT + 2) @(negedge clk);
    checkOutput("t4_adc_before", adc, 1);
    mode_in = 1'b0;
    @(negedge clk);
    checkOutput("t4_adc_drop", adc, 0);
    checkOutput("t4_latch_drop", latch, 0);
    checkOutput("t4_ready_low", ready, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("t4_ready_held_low", ready, 0);
    end
    checkOutput("t4_col_held", col_idx, ex_col);
    checkOutput("t4_overrun_held", overrun, 1);
    mode_in = 1'b1;
    @(negedge clk);
    checkOutput("t4_ready_back", ready, 1);
    next_ready_cyc = -1;
    applyStimulus(1'b0, MN);

    // vs coinciding with the last beat of column 20, row 3
    wait_ready(64);
    vs = 1'b1;
    @(posedge clk);
    #1;
    vs = 1'b0;
    ex_col = 0;
    ex_row = 0;
    @(negedge clk);
    checkOutput("t5_vs_idle_col", col_idx, 0);
    for (int i = 0; i < 3 * W + 20; i++) applyStimulus(1'b0, MN);
    wait_ready(64);
    checkOutput("t5_pre_col", col_idx, 20);
    checkOutput("t5_pre_row", row_idx, 3);
    applyStimulus(1'b0, MN);
    while (cyc < acc + RD_OFF + MN - 1) @(negedge clk);
    checkOutput("t5_last_beat", col_done, 1);
    vs = 1'b1;
    @(posedge clk);
    #1;
    vs = 1'b0;
    ex_col = 0;
    ex_row = 0;
    @(negedge clk);
    checkOutput("t5_col_cleared", col_idx, 0);
    checkOutput("t5_row_cleared", row_idx, 0);

    // Reset during read beat 2
    applyStimulus(1'b0, 3);
    while (cyc < acc + RD_OFF + 2) @(negedge clk);
    checkOutput("t6_beat2_sel", rd_sel, 2);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("t6_latch", latch, 0);
    checkOutput("t6_adc", adc, 0);
    checkOutput("t6_rd_e", rd_e, 0);
    checkOutput("t6_col_done", col_done, 0);
    checkOutput("t6_col", col_idx, 0);
    checkOutput("t6_row", row_idx, 0);
    checkOutput("t6_overrun", overrun, 0);
    checkOutput("t6_ready", ready, 0);
    rstn = 1'b0;
    ex_col = 0;
    ex_row = 0;
    next_ready_cyc = -1;
    @(negedge clk);
    checkOutput("t6_ready_back", ready, 1);
    applyStimulus(1'b0, MN);
    wait_ready(64);
    checkOutput("t6_col_after", col_idx, 1);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
